// File: rtl/vga_pkg.sv
// Shared VGA/board definitions: mouse FSM states and battleship grid geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StPresent,
    StHoldoff
  } mouse_state_t;

  localparam int unsigned BOARD_X0 = 100;
  localparam int unsigned BOARD_Y0 = 100;
  localparam int unsigned CELL     = 40;
  localparam int unsigned N_CELLS  = 10;

endpackage

// File: rtl/cell_div.sv
// Iterative subtract divider: converts grid-relative x/y offsets to column/row in
// exactly N_CELLS steps after a start pulse, then pulses o_done.
module cell_div #(
  parameter int unsigned CELL    = 40,
  parameter int unsigned N_CELLS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [11:0] i_rem_x,
  input  logic [11:0] i_rem_y,
  output logic [3:0]  o_col,
  output logic [3:0]  o_row,
  output logic        o_done
);

  localparam logic [11:0] CellW    = 12'(CELL);
  localparam logic [3:0]  LastIter = 4'(N_CELLS - 1);

  logic [11:0] r_rem_x, r_rem_y;
  logic [3:0]  r_col, r_row, r_iter;
  logic        r_busy, r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem_x <= '0;
      r_rem_y <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem_x <= i_rem_x;
        r_rem_y <= i_rem_y;
        r_col   <= '0;
        r_row   <= '0;
        r_iter  <= '0;
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        if (r_rem_x >= CellW) begin
          r_rem_x <= r_rem_x - CellW;
          r_col   <= r_col + 4'd1;
        end
        if (r_rem_y >= CellW) begin
          r_rem_y <= r_rem_y - CellW;
          r_row   <= r_row + 4'd1;
        end
        // Fixed iteration count keeps click-to-valid latency position independent.
        if (r_iter == LastIter) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        r_iter <= r_iter + 4'd1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_done = r_done;

endmodule

// File: rtl/mouse_pos_ctl.sv
// Clamps MouseCtl position to the visible area and turns left clicks into debounced
// grid-cell selections (valid/ready) or one-cycle miss pulses.
module mouse_pos_ctl #(
  parameter int unsigned X_MAX    = 799,
  parameter int unsigned Y_MAX    = 599,
  parameter int unsigned BOARD_X0 = vga_pkg::BOARD_X0,
  parameter int unsigned BOARD_Y0 = vga_pkg::BOARD_Y0,
  parameter int unsigned CELL     = vga_pkg::CELL,
  parameter int unsigned N_CELLS  = vga_pkg::N_CELLS,
  parameter int unsigned HOLDOFF  = 400_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        left_in,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        cell_valid,
  input  logic        cell_ready,
  output logic [3:0]  cell_col,
  output logic [3:0]  cell_row,
  output logic        miss_click
);

  import vga_pkg::*;

  localparam logic [11:0] XMaxW  = 12'(X_MAX);
  localparam logic [11:0] YMaxW  = 12'(Y_MAX);
  localparam logic [11:0] GridX0 = 12'(BOARD_X0);
  localparam logic [11:0] GridY0 = 12'(BOARD_Y0);
  localparam logic [11:0] GridX1 = 12'(BOARD_X0 + CELL * N_CELLS);
  localparam logic [11:0] GridY1 = 12'(BOARD_Y0 + CELL * N_CELLS);

  localparam int unsigned     HoldW    = $clog2(HOLDOFF);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF - 1);

  logic [11:0]      w_x_clamp, w_y_clamp, r_xpos, r_ypos;
  logic             r_left_q, w_click, w_in_grid;
  logic             w_div_start, w_div_done, w_miss_d, r_miss;
  logic [HoldW-1:0] r_hold_cnt;
  mouse_state_t     r_state, w_state_d;

  assign w_x_clamp = (xpos_in > XMaxW) ? XMaxW : xpos_in;
  assign w_y_clamp = (ypos_in > YMaxW) ? YMaxW : ypos_in;
  assign w_click   = left_in & ~r_left_q;
  assign w_in_grid = (w_x_clamp >= GridX0) && (w_x_clamp < GridX1) &&
                     (w_y_clamp >= GridY0) && (w_y_clamp < GridY1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xpos   <= '0;
      r_ypos   <= '0;
      r_left_q <= 1'b0;
      r_miss   <= 1'b0;
      r_state  <= StIdle;
    end else begin
      r_xpos   <= w_x_clamp;
      r_ypos   <= w_y_clamp;
      r_left_q <= left_in;
      r_miss   <= w_miss_d;
      r_state  <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_div_start = 1'b0;
    w_miss_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_click) begin
          if (w_in_grid) begin
            w_div_start = 1'b1;
            w_state_d   = StDiv;
          end else begin
            w_miss_d  = 1'b1;
            w_state_d = StHoldoff;
          end
        end
      end
      StDiv:     if (w_div_done) w_state_d = StPresent;
      StPresent: if (cell_ready) w_state_d = StHoldoff;
      // A still-held button parks here so it cannot retrigger.
      StHoldoff: if ((r_hold_cnt >= HoldLast) && !left_in) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if ((w_state_d == StHoldoff) && (r_state != StHoldoff)) begin
      r_hold_cnt <= '0;
    end else if ((r_state == StHoldoff) && (r_hold_cnt != HoldLast)) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  cell_div #(
    .CELL    (CELL),
    .N_CELLS (N_CELLS)
  ) u_cell_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_div_start),
    .i_rem_x (w_x_clamp - GridX0),
    .i_rem_y (w_y_clamp - GridY0),
    .o_col   (cell_col),
    .o_row   (cell_row),
    .o_done  (w_div_done)
  );

  assign xpos       = r_xpos;
  assign ypos       = r_ypos;
  assign cell_valid = (r_state == StPresent);
  assign miss_click = r_miss;

endmodule
